// File: rtl/eth_tx_frame_arbiter.sv
// Round-robin frame arbiter: merges PORTS AXI-stream requesters into one TX FIFO stream.
// A grant is held for a whole frame, and one idle cycle separates consecutive frames.
module eth_tx_frame_arbiter #(
  parameter int PORTS      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int USER_WIDTH = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [PORTS*DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [PORTS-1:0]              s_axis_tvalid,
  input  logic [PORTS-1:0]              s_axis_tlast,
  output logic [PORTS-1:0]              s_axis_tready,
  input  logic [PORTS*USER_WIDTH-1:0]   s_axis_tuser,
  input  logic [PORTS-1:0]              port_enable,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [USER_WIDTH-1:0]         m_axis_tuser,
  output logic [PORTS-1:0]              grant,
  output logic                          frame_done,
  output logic                          frame_bad
);

  localparam int IDX_W = $clog2(PORTS);

  typedef enum logic {IDLE, XFER} state_e;

  state_e           state_q, state_d;
  logic [PORTS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] last_grant_q, last_grant_d;
  logic [IDX_W-1:0] owner_idx;
  logic             fire;

  // First requester strictly after 'last', wrapping modulo PORTS.
  function automatic logic [PORTS-1:0] rr_pick(input logic [PORTS-1:0] req,
                                               input logic [IDX_W-1:0] last);
    logic [PORTS-1:0] pick;
    logic             found;
    int               idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= PORTS; k++) begin
      idx = int'(last) + k;
      if (idx >= PORTS) idx = idx - PORTS;
      if (!found && req[idx]) begin
        found     = 1'b1;
        pick[idx] = 1'b1;
      end
    end
    return pick;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(PORTS - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Passthrough mux; grant_q is zero in IDLE so every output falls to 0.
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = '0;
    s_axis_tready = '0;
    owner_idx     = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (state_q == XFER && grant_q[i]) begin
        m_axis_tdata     = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        m_axis_tvalid    = s_axis_tvalid[i];
        m_axis_tlast     = s_axis_tlast[i];
        m_axis_tuser     = s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
        s_axis_tready[i] = m_axis_tready;
        owner_idx        = IDX_W'(i);
      end
    end
  end

  assign fire       = (state_q == XFER) && m_axis_tvalid && m_axis_tready && m_axis_tlast;
  assign frame_done = fire;
  assign frame_bad  = fire && m_axis_tuser[0];
  assign grant      = grant_q;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (|(s_axis_tvalid & port_enable)) begin
          grant_d = rr_pick(s_axis_tvalid & port_enable, last_grant_q);
          state_d = XFER;
        end
      end
      XFER: begin
        if (fire) begin
          grant_d      = '0;
          last_grant_d = owner_idx;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// Randomized bench for eth_tx_frame_arbiter against an owner/last-grant reference model
// plus per-port frame sources.
module tb_eth_tx_frame_arbiter;
  localparam int P  = 4;
  localparam int DW = 8;
  localparam int UW = 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [P*DW-1:0]   s_axis_tdata;
  logic [P-1:0]      s_axis_tvalid, s_axis_tlast, s_axis_tready, port_enable;
  logic [P*UW-1:0]   s_axis_tuser;
  logic [DW-1:0]     m_axis_tdata;
  logic              m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [UW-1:0]     m_axis_tuser;
  logic [P-1:0]      grant;
  logic              frame_done, frame_bad;

  always #5 clk = ~clk;

  eth_tx_frame_arbiter #(.PORTS(P), .DATA_WIDTH(DW), .USER_WIDTH(UW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready), .s_axis_tuser(s_axis_tuser), .port_enable(port_enable),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser), .grant(grant),
    .frame_done(frame_done), .frame_bad(frame_bad)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Sources: port p sends bytes {p, seq[4:0]}; frame lengths and bad flags are per frame.
  int seq[P], bidx[P], flen[P];
  bit vld[P], bad[P], hs[P];
  int mode;             // 0: all valid, len 3; 1: random; 2: enable=1011, all valid
  int owner, lastg, owner_n, last_n;
  int done_cnt, port2_grants;
  int dut_order[$];
  logic [P-1:0] prev_grant;

  function automatic bit refill();
    if (mode == 1) return ($urandom_range(0, 9) < 6);
    return 1'b1;
  endfunction

  task automatic new_frame(input int p);
    bidx[p] = 0;
    flen[p] = (mode == 0) ? 3 : int'($urandom_range(1, 5));
    bad[p]  = (mode == 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
  endtask

  task automatic drive();
    for (int p = 0; p < P; p++) begin
      s_axis_tvalid[p]        = vld[p];
      s_axis_tdata[p*DW +: DW] = DW'((p << 5) | (seq[p] & 31));
      s_axis_tlast[p]         = (bidx[p] == flen[p] - 1);
      s_axis_tuser[p]         = bad[p];
    end
  endtask

  // Compare at the negedge, then compute what the model expects after the next posedge.
  task automatic eval_cycle();
    logic [P-1:0] eg, etr;
    logic ev, el, eu, fire;
    logic [DW-1:0] ed;
    eg = '0; etr = '0; ev = 0; el = 0; eu = 0; ed = '0; fire = 0;
    owner_n = owner; last_n = lastg;
    for (int p = 0; p < P; p++) hs[p] = 0;
    if (owner < 0) begin
      for (int k = 1; k <= P; k++) begin
        int q;
        q = (lastg + k) % P;
        if (owner_n < 0 && vld[q] && port_enable[q]) owner_n = q;
      end
    end else begin
      eg[owner]  = 1'b1;
      ev         = vld[owner];
      ed         = DW'((owner << 5) | (seq[owner] & 31));
      el         = (bidx[owner] == flen[owner] - 1);
      eu         = bad[owner];
      etr[owner] = m_axis_tready;
      hs[owner]  = vld[owner] && m_axis_tready;
      fire       = hs[owner] && el;
      if (fire) begin
        owner_n = -1;
        last_n  = owner;
      end
    end
    check_eq("grant", 32'(grant), 32'(eg));
    check_eq("m_tvalid", 32'(m_axis_tvalid), 32'(ev));
    check_eq("s_tready", 32'(s_axis_tready), 32'(etr));
    check_eq("frame_done", 32'(frame_done), 32'(fire));
    check_eq("frame_bad", 32'(frame_bad), 32'(fire && eu));
    if (ev) begin
      check_eq("m_tdata", 32'(m_axis_tdata), 32'(ed));
      check_eq("m_tlast", 32'(m_axis_tlast), 32'(el));
      check_eq("m_tuser", 32'(m_axis_tuser), 32'(eu));
    end
    if (frame_done) done_cnt++;
    if (grant[2]) port2_grants++;
    if (grant != '0 && prev_grant == '0)
      for (int p = 0; p < P; p++) if (grant[p]) dut_order.push_back(p);
    prev_grant = grant;
  endtask

  task automatic advance();
    owner = owner_n;
    lastg = last_n;
    for (int p = 0; p < P; p++) begin
      if (hs[p]) begin
        seq[p]++;
        if (bidx[p] == flen[p] - 1) new_frame(p);
        else bidx[p]++;
        vld[p] = refill();
      end else if (!vld[p]) begin
        vld[p] = refill();
      end
    end
    if (mode == 1) begin
      m_axis_tready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 9) == 0) port_enable = P'($urandom_range(0, (1 << P) - 1));
    end else begin
      m_axis_tready = 1'b1;
      port_enable   = (mode == 2) ? 4'b1011 : 4'b1111;
    end
    drive();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      eval_cycle();
      @(posedge clk);
      #1 advance();
    end
  endtask

  initial begin
    int budget;
    mode = 0; owner = -1; lastg = P - 1; done_cnt = 0; port2_grants = 0; prev_grant = '0;
    for (int p = 0; p < P; p++) begin seq[p] = 0; vld[p] = 1; hs[p] = 0; new_frame(p); end
    m_axis_tready = 1'b1;
    port_enable   = 4'b1111;
    drive();
    #12;
    check_eq("rst_grant", 32'(grant), 32'h0);
    check_eq("rst_m_tvalid", 32'(m_axis_tvalid), 32'h0);
    check_eq("rst_s_tready", 32'(s_axis_tready), 32'h0);
    check_eq("rst_done", 32'(frame_done), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // All ports valid, 3-beat frames: 4 cycles per frame, strict rotation.
    run(20);
    check_eq("rr_done_count", 32'(done_cnt), 32'd5);
    check_eq("rr_order_len", 32'(dut_order.size()), 32'd5);
    for (int k = 0; k < 5 && k < dut_order.size(); k++)
      check_eq("rr_order", 32'(dut_order[k]), 32'(k % P));

    mode = 2; port2_grants = 0;
    run(60);
    check_eq("disabled_port2", 32'(port2_grants), 32'd0);

    mode = 1;
    run(3000);

    // Asynchronous reset in the middle of a frame.
    budget = 0;
    while (owner < 0 && budget < 200) begin run(1); budget++; end
    check_eq("rst_wait_owner", 32'(owner >= 0), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_grant", 32'(grant), 32'h0);
    check_eq("midrst_m_tvalid", 32'(m_axis_tvalid), 32'h0);
    check_eq("midrst_s_tready", 32'(s_axis_tready), 32'h0);
    owner = -1; lastg = P - 1;
    mode = 0;
    for (int p = 0; p < P; p++) begin hs[p] = 0; vld[p] = 1; end
    m_axis_tready = 1'b1;
    port_enable   = 4'b1111;
    drive();
    @(posedge clk);
    #1 rst_n = 1'b1;
    dut_order.delete();
    prev_grant = '0;
    run(30);
    check_eq("post_rst_first", (dut_order.size() > 0) ? 32'(dut_order[0]) : 32'hFFFF, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
